reg_file: RTL

Architectural register file with per-register rename tags, sitting directly downstream of the reorder buffer's commit port and beside the decoder. Commits write architectural values and retire rename tags. Issues mark a destination register busy with the ROB slot that will produce it. The decoder reads operands combinationally: value if clean, producing ROB position if busy.

---
 rtl/reg_file.sv | 105 ++++++++++
 1 files changed

// File: rtl/reg_file.sv
// reg_file: architectural registers with rename tags, commit bypass reads.
// clk/rst(async, low)/rdy; issue_* renames; reg_* commits; rs1/rs2 reads.
module reg_file #(
  parameter int REG_NUM       = 32,
  parameter int REG_POS_WIDTH = 5,
  parameter int ROB_POS_WIDTH = 4,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     rollback,
  input  logic                     issue,
  input  logic [REG_POS_WIDTH-1:0] issue_rd,
  input  logic [ROB_POS_WIDTH-1:0] issue_rob_pos,
  input  logic                     reg_write,
  input  logic [REG_POS_WIDTH-1:0] reg_rd,
  input  logic [DATA_WIDTH-1:0]    reg_val,
  input  logic [ROB_POS_WIDTH-1:0] commit_rob_pos,
  input  logic [REG_POS_WIDTH-1:0] rs1_pos,
  input  logic [REG_POS_WIDTH-1:0] rs2_pos,
  output logic [DATA_WIDTH-1:0]    rs1_val,
  output logic [DATA_WIDTH-1:0]    rs2_val,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  output logic [ROB_POS_WIDTH-1:0] rs1_rob_pos,
  output logic [ROB_POS_WIDTH-1:0] rs2_rob_pos
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    v;
    logic                     b;
    logic [ROB_POS_WIDTH-1:0] t;
  } rd_t;

  logic [DATA_WIDTH-1:0]    val_q [REG_NUM];
  logic [ROB_POS_WIDTH-1:0] tag_q [REG_NUM];
  logic [REG_NUM-1:0]       busy_q;

  logic wr_en;
  logic is_en;

  assign wr_en = reg_write && (reg_rd != '0);
  assign is_en = issue && (issue_rd != '0);

  // x0 is never written, so it keeps its reset zeros forever.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
      busy_q <= '0;
    end else if (rdy) begin
      if (wr_en) begin
        val_q[reg_rd] <= reg_val;
        if (busy_q[reg_rd] &&
            tag_q[reg_rd] == commit_rob_pos)
          busy_q[reg_rd] <= 1'b0;
      end
      // Later assignments win: a same-cycle
      // rename overrides the commit's clear.
      if (rollback) begin
        busy_q <= '0;
      end else if (is_en) begin
        busy_q[issue_rd] <= 1'b1;
        tag_q[issue_rd]  <= issue_rob_pos;
      end
    end
  end

  function automatic rd_t rd_port(
    input logic [REG_POS_WIDTH-1:0] p
  );
    rd_t r;
    r = '0;
    if (p != '0) begin
      r.v = val_q[p];
      r.b = busy_q[p];
      r.t = tag_q[p];
      // Matching commit this cycle: forward it.
      if (reg_write && reg_rd == p &&
          busy_q[p] &&
          tag_q[p] == commit_rob_pos) begin
        r.v = reg_val;
        r.b = 1'b0;
      end
    end
    return r;
  endfunction

  rd_t r1;
  rd_t r2;

  assign r1 = rd_port(rs1_pos);
  assign r2 = rd_port(rs2_pos);

  assign rs1_val     = r1.v;
  assign rs1_busy    = r1.b;
  assign rs1_rob_pos = r1.t;
  assign rs2_val     = r2.v;
  assign rs2_busy    = r2.b;
  assign rs2_rob_pos = r2.t;

endmodule
